// File: rtl/level_sequencer_pkg.sv
// Shared game definitions: state encodings and level limits used by the
// sequencer and by the display block's win/blink compare.
package level_sequencer_pkg;

  localparam int LVL_W = 3;
  localparam logic [LVL_W-1:0] MAXLVL_DEF = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } state_t;

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser followed by a rising-edge detector; a held button
// yields a single one-cycle pulse.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic In,
  output logic Pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  // NOTE: non-blocking assignments make each flop sample the previous stage's
  // old value, which is what turns these three lines into a shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= In;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign Pulse = sync2 & ~prev;

endmodule

// File: rtl/level_sequencer.sv
// Game-flow controller: IDLE -> PLAY -> WIN/LOSE with a per-level time limit,
// driving the level bus and status flags for the score display.
module level_sequencer
  import level_sequencer_pkg::*;
#(
  parameter logic [LVL_W-1:0] MAXLVL   = MAXLVL_DEF,
  parameter int               PRE_W    = 20,
  parameter int               TW       = 4,
  parameter logic [TW-1:0]    LVL_TIME = TW'(10)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic             Hit,
  input  logic             Miss,
  output logic [LVL_W-1:0] Lvl,
  output logic             Playing,
  output logic             Win,
  output logic             Lose,
  output logic [TW-1:0]    TimeLeft
);

  state_t           state;
  logic [PRE_W-1:0] prescaler;
  logic             start_p;
  logic             hit_p;
  logic             miss_p;
  logic             tick;
  logic [LVL_W-1:0] lvl_next;

  btn_edge u_start (.clk(clk), .rst(rst), .In(Start), .Pulse(start_p));
  btn_edge u_hit   (.clk(clk), .rst(rst), .In(Hit),   .Pulse(hit_p));
  btn_edge u_miss  (.clk(clk), .rst(rst), .In(Miss),  .Pulse(miss_p));

  assign tick     = &prescaler;
  assign lvl_next = Lvl + LVL_W'(1);

  // Flags are written alongside every state change so they stay one-hot with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      Lvl       <= '0;
      TimeLeft  <= '0;
      prescaler <= '0;
      Playing   <= 1'b0;
      Win       <= 1'b0;
      Lose      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          Lvl <= '0;
          if (start_p) begin
            state     <= ST_PLAY;
            Playing   <= 1'b1;
            TimeLeft  <= LVL_TIME;
            prescaler <= '0;
          end
        end

        ST_PLAY: begin
          prescaler <= prescaler + PRE_W'(1);
          if (miss_p) begin
            state   <= ST_LOSE;
            Playing <= 1'b0;
            Lose    <= 1'b1;
          end else if (hit_p) begin
            // A hit landing on the final tick still wins: the timer reloads.
            Lvl      <= lvl_next;
            TimeLeft <= LVL_TIME;
            if (lvl_next == MAXLVL) begin
              state   <= ST_WIN;
              Playing <= 1'b0;
              Win     <= 1'b1;
            end
          end else if (tick) begin
            TimeLeft <= TimeLeft - TW'(1);
            if (TimeLeft == TW'(1)) begin
              state   <= ST_LOSE;
              Playing <= 1'b0;
              Lose    <= 1'b1;
            end
          end
        end

        ST_WIN, ST_LOSE: begin
          if (start_p) begin
            state    <= ST_IDLE;
            Lvl      <= '0;
            TimeLeft <= '0;
            Win      <= 1'b0;
            Lose     <= 1'b0;
          end
        end

        default: begin
          state    <= ST_IDLE;
          Lvl      <= '0;
          TimeLeft <= '0;
          Playing  <= 1'b0;
          Win      <= 1'b0;
          Lose     <= 1'b0;
        end
      endcase
    end
  end

endmodule
